// File: rtl/sll32_arbiter.sv
// ---------------------------------------------------------------------------
// sll32_arbiter
//
// Purpose:
//   Two requesters share one combinational 32-bit logical-left shifter. The
//   shifter's input is picked by a round-robin arbiter, or by a fixed-priority
//   arbiter when PRIO_FIXED=1. The shifted value goes into a one-entry output
//   register together with the id of the requester that won. Draining and
//   capturing can happen in the same cycle, so one shift per cycle is
//   sustained while the consumer keeps out_ready high.
//
// Parameters:
//   PRIO_FIXED  0 = round-robin between req0 and req1, 1 = req0 always wins
//
// Ports:
//   clk          in   1   system clock, rising edge
//   rst_n        in   1   asynchronous active-low reset
//   req0_valid   in   1   requester 0 has an operand
//   req0_ready   out  1   requester 0 operand accepted this cycle
//   req0_data    in   32  requester 0 operand
//   req0_shamt   in   5   requester 0 shift amount
//   req1_valid   in   1   requester 1 has an operand
//   req1_ready   out  1   requester 1 operand accepted this cycle
//   req1_data    in   32  requester 1 operand
//   req1_shamt   in   5   requester 1 shift amount
//   out_valid    out  1   out_result/out_id hold a result
//   out_ready    in   1   consumer accepts the result
//   out_result   out  32  data << shamt, zero-filled
//   out_id       out  1   requester that produced out_result
// ---------------------------------------------------------------------------
module sll32_arbiter #(
  parameter int unsigned PRIO_FIXED = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_data,
  input  logic [4:0]  req0_shamt,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_data,
  input  logic [4:0]  req1_shamt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_id
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t      state;
  state_t      next_state;
  logic        last_grant;
  logic        can_accept;
  logic        grant0;
  logic        grant1;
  logic        take0;
  logic        take1;
  logic        take_any;
  logic [31:0] sel_data;
  logic [4:0]  sel_shamt;
  logic [31:0] shifted;

  // Log-depth barrel shifter. Each stage shifts by a power of two, so bits
  // pushed past bit 31 fall off and every shift amount 0..31 is exact.
  function automatic logic [31:0] sll32(input logic [31:0] d,
                                        input logic [4:0]  s);
    logic [31:0] v;
    v = d;
    if (s[0]) v = {v[30:0], 1'b0};
    if (s[1]) v = {v[29:0], 2'b0};
    if (s[2]) v = {v[27:0], 4'b0};
    if (s[3]) v = {v[23:0], 8'b0};
    if (s[4]) v = {v[15:0], 16'b0};
    return v;
  endfunction

  assign out_valid = (state == FULL);

  // Arbitration and handshake. With both requesters valid, round-robin picks
  // the one that was not granted last time. Nothing is granted while the
  // output register is full and stalled, so the readies stay low then.
  always_comb begin
    can_accept = (state == EMPTY) | out_ready;
    grant0     = 1'b0;
    grant1     = 1'b0;
    if (req0_valid && req1_valid) begin
      if ((PRIO_FIXED != 0) || last_grant) begin
        grant0 = 1'b1;
      end else begin
        grant1 = 1'b1;
      end
    end else if (req0_valid) begin
      grant0 = 1'b1;
    end else if (req1_valid) begin
      grant1 = 1'b1;
    end
    req0_ready = grant0 & can_accept;
    req1_ready = grant1 & can_accept;
    take0      = req0_valid & req0_ready;
    take1      = req1_valid & req1_ready;
    take_any   = take0 | take1;
  end

  // The shared shifter gets the operand of whichever requester is granted.
  always_comb begin
    sel_data  = req0_data;
    sel_shamt = req0_shamt;
    if (grant1) begin
      sel_data  = req1_data;
      sel_shamt = req1_shamt;
    end
    shifted = sll32(sel_data, sel_shamt);
  end

  // Output occupancy. A capture while FULL with out_ready high is a
  // simultaneous drain and refill, so the state stays FULL.
  always_comb begin
    next_state = state;
    case (state)
      EMPTY: begin
        if (take_any) next_state = FULL;
      end
      FULL: begin
        if (take_any)       next_state = FULL;
        else if (out_ready) next_state = EMPTY;
      end
      default: next_state = EMPTY;
    endcase
  end

  // State register. last_grant resets to 1 so req0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= next_state;
    end
  end

  // Result register and round-robin pointer. Both change only on an accepted
  // transfer. A bare drain leaves the old result and id in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_result <= 32'h0;
      out_id     <= 1'b0;
      last_grant <= 1'b1;
    end else if (take_any) begin
      out_result <= shifted;
      out_id     <= take1;
      last_grant <= take1;
    end
  end

endmodule
